// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide engine:
// funct3 encodings, FSM state type and iteration count.
package ex_muldiv_unit_pkg;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

    localparam int DIV_ITERS = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } muldiv_state_t;

    // Two's-complement negate when neg is set; used for |x| and sign restore.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage <-> muldiv engine signal bundle; the engine side uses the slave modport.
interface ex_muldiv_unit_if;
    import ex_muldiv_unit_pkg::*;

    // valid_i is held by EX for the whole op; stall_o freezes the front end until
    // done_o, and the result is consumed in the cycle done_o is high and hold_i is low.
    logic          valid_i;
    logic [2:0]    op_i;
    logic [31:0]   rs1_i;
    logic [31:0]   rs2_i;
    logic          flush_i;
    logic          hold_i;
    logic          stall_o;
    logic          done_o;
    logic [31:0]   result_o;
    logic          busy_o;
    muldiv_state_t state_o;

    modport master (
        output valid_i, op_i, rs1_i, rs2_i, flush_i, hold_i,
        input  stall_o, done_o, result_o, busy_o, state_o
    );

    modport slave (
        input  valid_i, op_i, rs1_i, rs2_i, flush_i, hold_i,
        output stall_o, done_o, result_o, busy_o, state_o
    );

endinterface

// File: rtl/ex_muldiv_unit_div_step.sv
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
module muldiv_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quo_next
);

    logic [W:0]   rem_sh;
    logic [W-1:0] diff;
    logic         borrow;

    // quo carries the unconsumed dividend bits in its upper part and collects
    // quotient bits from the bottom as they are produced.
    assign rem_sh   = {rem, quo[W-1]};
    assign borrow   = rem_sh < {1'b0, divisor};
    assign diff     = rem_sh[W-1:0] - divisor;
    assign rem_next = borrow ? rem_sh[W-1:0] : diff;
    assign quo_next = {quo[W-2:0], ~borrow};

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide engine living in EX; stalls the front end
// until the result is ready and presents it for one (or more, under hold) cycle.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_muldiv_unit_if.slave  bus
);

    muldiv_state_t   state_q, state_d;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, rem_q, result_q;
    logic [4:0]      cnt_q;
    logic            s1_q, s2_q, bz_q;

    logic            accept, rs2_zero, div_ovf, special;
    logic            s1_in, s2_in;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] rem_next, quo_next;

    logic signed [32:0] a33, b33;
    logic signed [63:0] prod;
    logic [XLEN-1:0]    mul_res;

    assign accept   = (state_q == IDLE) && bus.valid_i && !bus.flush_i;
    assign rs2_zero = (bus.rs2_i == '0);
    // Signed divides (DIV/REM) have funct3 bit 0 clear.
    assign s1_in    = ~bus.op_i[0] & bus.rs1_i[XLEN-1];
    assign s2_in    = ~bus.op_i[0] & bus.rs2_i[XLEN-1];
    assign div_ovf  = ~bus.op_i[0] && (bus.rs1_i == 32'h8000_0000) && (bus.rs2_i == 32'hFFFF_FFFF);
    assign special  = FAST_SPECIAL && bus.op_i[2] && (rs2_zero || div_ovf);

    always_comb begin
        special_res = '0;
        if (rs2_zero) special_res = bus.op_i[1] ? bus.rs1_i : '1;
        else          special_res = bus.op_i[1] ? '0 : 32'h8000_0000;
    end

    // MULH treats both operands as signed, MULHSU only rs1; MUL/MULHU zero-extend.
    assign a33     = {((op_q == MULDIV_OP_MULH) || (op_q == MULDIV_OP_MULHSU)) & a_q[XLEN-1], a_q};
    assign b33     = {(op_q == MULDIV_OP_MULH) & b_q[XLEN-1], b_q};
    assign prod    = 64'(a33) * 64'(b33);
    assign mul_res = (op_q == MULDIV_OP_MUL) ? prod[31:0] : prod[63:32];

    muldiv_div_step #(.W(XLEN)) u_div_step (
        .rem      (rem_q),
        .quo      (a_q),
        .divisor  (b_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (bus.valid_i) state_d = !bus.op_i[2] ? MUL : (special ? DONE : DIV);
                MUL:  state_d = DONE;
                DIV:  if (cnt_q == 5'(DIV_ITERS - 1)) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: if (!bus.hold_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.done_o  = (state_q == DONE);
        bus.busy_o  = (state_q != IDLE);
        bus.stall_o = bus.valid_i && (state_q != DONE) && !bus.flush_i;
    end

    assign bus.result_o = result_q;
    assign bus.state_o  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            bz_q     <= 1'b0;
        end else if (accept) begin
            op_q <= bus.op_i;
            s1_q <= s1_in;
            s2_q <= s2_in;
            bz_q <= rs2_zero;
            if (!bus.op_i[2]) begin
                a_q <= bus.rs1_i;
                b_q <= bus.rs2_i;
            end else if (special) begin
                result_q <= special_res;
            end else begin
                a_q   <= neg_if(bus.rs1_i, s1_in);
                b_q   <= neg_if(bus.rs2_i, s2_in);
                rem_q <= '0;
                cnt_q <= '0;
            end
        end else if (!bus.flush_i) begin
            unique case (state_q)
                MUL: result_q <= mul_res;
                DIV: begin
                    a_q   <= quo_next;
                    rem_q <= rem_next;
                    cnt_q <= cnt_q + 5'd1;
                end
                // A zero divisor keeps the all-ones quotient regardless of dividend sign.
                FIX: result_q <= op_q[1] ? neg_if(rem_q, s1_q)
                                         : neg_if(a_q, (s1_q ^ s2_q) & ~bz_q);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: driver issues ops and checks timing,
// a done_o monitor pops the expected-result queue and checks values.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_unit_if bus();

  ex_muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;
  logic        prev_done = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: a rising done_o consumes one expected result; while done_o stays
  // high the result must not move.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done_o && !prev_done) begin
        check("done_has_expect", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          last_exp = exp_q.pop_front();
          check("result", bus.result_o, last_exp);
        end
      end else if (bus.done_o && prev_done) begin
        check("result_stable", bus.result_o, last_exp);
      end
    end
    prev_done = rst_n & bus.done_o;
  end

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
  endtask

  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int exp_lat, input int hold_cyc);
    int lat = 0;
    int stalls = 0;
    int done_cyc = 1;
    bit seen = 0;
    start_op(op, a, b);
    exp_q.push_back(exp_res);
    #1;
    if (bus.stall_o) stalls++;
    while (!seen && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      // Operands after accept must not matter.
      bus.rs1_i = $urandom_range(32'hFFFF_FFFF, 0);
      bus.rs2_i = $urandom_range(32'hFFFF_FFFF, 0);
      if (bus.done_o) seen = 1;
      else if (bus.stall_o) stalls++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
    bus.valid_i = 1'b0;
    bus.hold_i  = (hold_cyc > 0);
    for (int i = 0; i < hold_cyc; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) done_cyc++;
    end
    bus.hold_i = 1'b0;
    if (hold_cyc > 0) check({name, "_hold_done_cycles"}, 32'(done_cyc), 32'(hold_cyc + 1));
    @(posedge clk);
    #1;
    check({name, "_back_to_idle"}, 32'(bus.state_o), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_i = 1'b0;
    bus.op_i    = 3'd0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    bus.flush_i = 1'b0;
    bus.hold_i  = 1'b0;

    // Reset values and combinational stall during reset.
    #2;
    check("rst_result", bus.result_o, 32'd0);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    bus.valid_i = 1'b1;
    #1;
    check("rst_stall_valid1", {31'd0, bus.stall_o}, 32'd1);
    bus.valid_i = 1'b0;
    #1;
    check("rst_stall_valid0", {31'd0, bus.stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    issue("mul_7x-3",      MULDIV_OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 0);
    issue("mulh_min",      MULDIV_OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2, 0);
    issue("mulhsu_min",    MULDIV_OP_MULHSU, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, 2, 0);
    issue("mulhu_min",     MULDIV_OP_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2, 0);
    issue("mulhu_max",     MULDIV_OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0);
    issue("div_-20_3",     MULDIV_OP_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 34, 0);
    issue("rem_-20_3",     MULDIV_OP_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 34, 0);
    issue("divu_100_7",    MULDIV_OP_DIVU,   32'd100,        32'd7,         32'd14,        34, 0);
    issue("remu_100_7",    MULDIV_OP_REMU,   32'd100,        32'd7,         32'd2,         34, 0);
    issue("div_7_-2",      MULDIV_OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0);
    issue("rem_7_-2",      MULDIV_OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         34, 0);
    issue("div_5_0",       MULDIV_OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0);
    issue("remu_5_0",      MULDIV_OP_REMU,   32'd5,          32'd0,         32'd5,         1, 0);
    issue("div_ovf",       MULDIV_OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    issue("rem_ovf",       MULDIV_OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 0);
    issue("mul_hold",      MULDIV_OP_MUL,    32'd6,          32'd7,         32'd42,        2, 3);

    // Flush at the tenth DIV cycle: abort, no done pulse.
    start_op(MULDIV_OP_DIV, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    check("flush_in_div", 32'(bus.state_o), 32'(DIV));
    bus.flush_i = 1'b1;
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("flush_to_idle", 32'(bus.state_o), 32'(IDLE));
    check("flush_not_busy", {31'd0, bus.busy_o}, 32'd0);
    bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_done", {31'd0, bus.done_o}, 32'd0);
    issue("mul_3x4", MULDIV_OP_MUL, 32'd3, 32'd4, 32'd12, 2, 0);

    // Asynchronous reset in the middle of a divide.
    start_op(MULDIV_OP_DIV, 32'd1000, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    check("middiv_busy", {31'd0, bus.busy_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_result", bus.result_o, 32'd0);
    check("arst_done", {31'd0, bus.done_o}, 32'd0);
    check("arst_state", 32'(bus.state_o), 32'(IDLE));
    check("arst_stall", {31'd0, bus.stall_o}, 32'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    issue("divu_max_1", MULDIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide engine in the EX stage.
- Consumes the EX-stage operands, funct3 and is_muldiv control produced by the ID/EX pipeline register.
- Holds the pipeline through the hazard unit until the result is ready.
- Returns a 32-bit result that the EX stage forwards into EX/MEM in place of the ALU result.

Parameters:
- XLEN, 32: operand/result width; only 32 supported.
- FAST_SPECIAL, 1: when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_i  input  1  EX holds an M-extension op (ex_is_muldiv != 0).
- op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i  input  32  forwarded rs1 operand (dividend / multiplicand).
- rs2_i  input  32  forwarded rs2 operand (divisor / multiplier).
- flush_i  input  1  EX flush from hazard unit; aborts the operation.
- hold_i  input  1  downstream freeze; EX must not advance.
- stall_o  output  1  request to freeze PC, IF/ID and ID/EX.
- done_o  output  1  result_o valid this cycle.
- result_o  output  32  operation result.
- busy_o  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; result_o=0, done_o=0, busy_o=0.
  - Internal operand, quotient, remainder and count registers go to 0.
  - stall_o is combinational and equals valid_i during reset.
- stall_o = valid_i & (state != DONE) & !flush_i.
- FSM states IDLE, MUL, DIV, FIX, DONE:
  - IDLE:
    - valid_i & !flush_i: latch rs1/rs2/op and record operand signs.
    - op<4 -> MUL.
    - op>=4 with FAST_SPECIAL and rs2==0 -> DONE. Result: DIV/DIVU = 32'hFFFF_FFFF; REM/REMU = rs1.
    - op>=4 with FAST_SPECIAL, signed op, rs1=32'h8000_0000, rs2=32'hFFFF_FFFF -> DONE. Result: DIV = 32'h8000_0000; REM = 0.
    - Any other divide -> DIV with count=0, using absolute values for signed ops.
  - MUL:
    - Form 33-bit operands, sign- or zero-extended per op. MULHSU: rs1 signed, rs2 unsigned.
    - Form a 66-bit product; register product[31:0] for MUL, product[63:32] otherwise -> DONE.
  - DIV:
    - One restoring step per cycle: shift remainder left by 1 and bring in the dividend MSB.
    - Subtract the divisor if no borrow; the quotient bit = !borrow.
    - Count increments each cycle; count==31 -> FIX. Always exactly 32 DIV cycles.
    - With FAST_SPECIAL=0, divide by zero also iterates; the restoring algorithm yields the same spec results.
  - FIX:
    - Quotient is negated when dividend and divisor signs differ (signed ops only).
    - Remainder takes the dividend sign.
    - Select quotient or remainder by op; register into result_o -> DONE.
  - DONE:
    - done_o=1 and stall_o=0, so the pipeline advances and EX/MEM captures result_o.
    - Stay in DONE while hold_i, with done_o held high and result_o stable.
    - Otherwise -> IDLE.
- Latency from the accept cycle T (IDLE with valid_i):
  - MUL*: done at T+2; stall_o high for T and T+1.
  - Divide, normal: done at T+34.
  - Divide, special case: done at T+1.
- Back-to-back M ops: after DONE->IDLE the next valid_i is accepted in that IDLE cycle. One idle accept cycle per op; no overlap.
- flush_i:
  - In any state, the next state is IDLE; done_o is not asserted for the aborted op.
  - flush_i together with valid_i in IDLE: op not accepted.
  - flush_i in DONE: done_o still high that cycle; the flushed EX/MEM write is the hazard unit's responsibility.
- Operand changes on rs1_i/rs2_i after accept are ignored; only latched copies are used.
- result_o retains its last value outside DONE.

Decomposition:
- Shared definitions package:
  - MULDIV_OP_* funct3 constants (MUL..REMU).
  - muldiv_state_t enum {IDLE, MUL, DIV, FIX, DONE}.
  - DIV_ITERS = 32.
- One sub-module: muldiv_div_step.
  - Combinational single restoring iteration.
  - Inputs: rem, quo, divisor. Outputs: next rem, next quo.
  - Instanced once inside the DIV state datapath.

Test Plan:
- MUL 7 x -3 (rs1=7, rs2=32'hFFFF_FFFD, op=0) -> done_o at T+2, result_o=32'hFFFF_FFEB; stall_o high exactly 2 cycles.
- MULH/MULHSU/MULHU with rs1=rs2=32'h8000_0000 -> 32'h4000_0000 / 32'hC000_0000 / 32'h4000_0000.
- DIV -20/3 and REM -20/3 -> quotient 32'hFFFF_FFFA (-6), remainder 32'hFFFF_FFFE (-2); done_o at T+34. DIVU 100/7=14, REMU 100/7=2.
- Divide-by-zero: DIV 5/0 -> 32'hFFFF_FFFF; REMU 5/0 -> 5; done at T+1. Overflow: DIV 32'h8000_0000 / -1 -> 32'h8000_0000; REM -> 0.
- flush_i asserted at DIV cycle 10 -> IDLE next cycle, no done_o pulse; a following MUL 3x4 returns 12 at T+2.
- hold_i held 3 cycles in DONE -> done_o and result_o stable for 4 cycles. rst_n asserted mid-DIV -> state IDLE, result_o=0 and done_o=0 immediately, without waiting for a clock edge.
